// File: rtl/entrada_operandos_pkg.sv
// Shared types and the switch-to-operand field mapping for the operand input stage.
package entrada_pkg;

  typedef enum logic [1:0] {
    MODO_A13  = 2'b00,
    MODO_PAR6 = 2'b01,
    MODO_A14  = 2'b10,
    MODO_NULO = 2'b11
  } modo_t;

  localparam int unsigned MAX_SW = 32;

  typedef struct packed {
    logic [MAX_SW-1:0] a;
    logic [MAX_SW-1:0] b;
  } campos_t;

  function automatic logic [MAX_SW-1:0] mascara(input int unsigned n);
    logic [MAX_SW-1:0] uno;
    uno = 1;
    return (n >= MAX_SW) ? '1 : ((uno << n) - uno);
  endfunction

  // Operands are built at full MAX_SW width; the top truncates to W_OP.
  function automatic campos_t mapear_campos(
    input logic [MAX_SW-1:0] sw,
    input modo_t             modo,
    input int unsigned       w_uno,
    input int unsigned       w_par,
    input int unsigned       w_op
  );
    campos_t c;
    c = '0;
    case (modo)
      MODO_A13:  c.a = sw & mascara(w_uno);
      MODO_PAR6: begin
        c.a = sw & mascara(w_par);
        c.b = (sw >> w_par) & mascara(w_par);
      end
      MODO_A14:  c.a = sw & mascara(w_op);
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/entrada_operandos_antirrebote.sv
// Load-button synchroniser and debouncer; emits a one-cycle pulse on each accepted press.
module antirrebote #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_subida
);

  localparam int unsigned W_CNT = $clog2(DEB_CYCLES + 1);

  generate
    if (DEB_CYCLES < 2) begin : g_err_deb
      $error("antirrebote: DEB_CYCLES must be >= 2");
    end
  endgenerate

  logic [1:0]       r_sinc;
  logic             r_deb;
  logic             r_deb_d;
  logic [W_CNT-1:0] r_cnt;
  logic             w_btn;

  assign w_btn = r_sinc[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sinc  <= '0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sinc  <= {r_sinc[0], i_btn};
      r_deb_d <= r_deb;
      if (w_btn == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == W_CNT'(DEB_CYCLES - 1)) begin
        // The increment that would reach DEB_CYCLES is the toggle edge itself.
        r_deb <= ~r_deb;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_subida = r_deb & ~r_deb_d;

endmodule

// File: rtl/entrada_operandos.sv
// Synchronises switches/mode, debounces the load button and presents captured
// operands to the datapath through a valid/ready handshake.
module entrada_operandos
  import entrada_pkg::*;
#(
  parameter int unsigned N_SW       = 16,
  parameter int unsigned W_OP       = 14,
  parameter int unsigned W_UNO      = 13,
  parameter int unsigned W_PAR      = 6,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw,
  input  logic [1:0]      modo,
  input  logic            btn_carga,
  input  logic            op_ready,
  output logic [W_OP-1:0] binA,
  output logic [W_OP-1:0] binB,
  output logic [1:0]      modo_q,
  output logic            op_valid,
  output logic            overrun,
  output logic            modo_err
);

  generate
    if (!(W_UNO <= W_OP && W_OP <= N_SW)) begin : g_err_anchos
      $error("entrada_operandos: requires W_UNO <= W_OP <= N_SW");
    end
    if (2 * W_PAR > N_SW) begin : g_err_par
      $error("entrada_operandos: requires 2*W_PAR <= N_SW");
    end
    if (W_PAR > W_OP) begin : g_err_par_op
      $error("entrada_operandos: requires W_PAR <= W_OP");
    end
    if (N_SW > MAX_SW) begin : g_err_max
      $error("entrada_operandos: N_SW exceeds MAX_SW");
    end
    if (DEB_CYCLES < 2) begin : g_err_deb
      $error("entrada_operandos: DEB_CYCLES must be >= 2");
    end
  endgenerate

  logic [N_SW-1:0]   r_sw_s1;
  logic [N_SW-1:0]   r_sw_s2;
  logic [1:0]        r_modo_s1;
  logic [1:0]        r_modo_s2;

  logic [W_OP-1:0]   r_binA;
  logic [W_OP-1:0]   r_binB;
  modo_t             r_modo_q;
  logic              r_valid;
  logic              r_overrun;
  logic              r_modo_err;

  logic              w_carga;
  logic              w_xfer;
  modo_t             w_modo;
  logic [MAX_SW-1:0] w_sw_ext;
  campos_t           w_campos;
  logic [W_OP-1:0]   w_a;
  logic [W_OP-1:0]   w_b;

  antirrebote #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_antirrebote (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_btn   (btn_carga),
    .o_subida(w_carga)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_s1   <= '0;
      r_sw_s2   <= '0;
      r_modo_s1 <= '0;
      r_modo_s2 <= '0;
    end else begin
      r_sw_s1   <= sw;
      r_sw_s2   <= r_sw_s1;
      r_modo_s1 <= modo;
      r_modo_s2 <= r_modo_s1;
    end
  end

  always_comb begin
    w_modo   = modo_t'(r_modo_s2);
    w_sw_ext = MAX_SW'(r_sw_s2);
    w_campos = mapear_campos(w_sw_ext, w_modo, W_UNO, W_PAR, W_OP);
    w_a      = W_OP'(w_campos.a);
    w_b      = W_OP'(w_campos.b);
  end

  assign w_xfer = r_valid & op_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_binA     <= '0;
      r_binB     <= '0;
      r_modo_q   <= MODO_A13;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
      r_modo_err <= 1'b0;
    end else begin
      r_overrun  <= 1'b0;
      r_modo_err <= 1'b0;
      if (w_xfer) begin
        r_valid <= 1'b0;
      end
      // A load in the same cycle as a transfer overrides the clear above.
      if (w_carga) begin
        if (w_modo == MODO_NULO) begin
          r_modo_err <= 1'b1;
        end else if (r_valid && !w_xfer) begin
          r_overrun <= 1'b1;
        end else begin
          r_binA   <= w_a;
          r_binB   <= w_b;
          r_modo_q <= w_modo;
          r_valid  <= 1'b1;
        end
      end
    end
  end

  assign binA     = r_binA;
  assign binB     = r_binB;
  assign modo_q   = r_modo_q;
  assign op_valid = r_valid;
  assign overrun  = r_overrun;
  assign modo_err = r_modo_err;

endmodule
